// File: rtl/lif_neuron_scheduler.sv
// lif_neuron_scheduler: one shared LIF update datapath swept over N_NEURONS virtual neurons per tick.
// Optional refractory counters are enabled with `define LIF_SCHED_REFRACTORY_EN.
module lif_neuron_scheduler #(
  parameter int N_NEURONS     = 4,
  parameter int WIDTH         = 8,
  parameter int THRESHOLD     = 200,
  parameter int LEAK_SHIFT    = 1,
  parameter int REFRACT_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]             cfg_data,
  input  logic                         tick,
  input  logic [$clog2(N_NEURONS)-1:0] rd_addr,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         busy,
  output logic                         done,
  output logic [N_NEURONS-1:0]         spike_vec,
  output logic [7:0]                   spike_count,
  output logic                         overrun
);
  localparam int AW = $clog2(N_NEURONS);
  localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
  state_t st, st_nx;
  logic [WIDTH-1:0] v [N_NEURONS];
  logic [WIDTH-1:0] cur [N_NEURONS];
  logic [AW-1:0] idx;
  logic [N_NEURONS-1:0] shadow;
  logic [WIDTH-1:0] v_cur, v_nx, sat;
  logic [WIDTH:0] sum;
  logic last, fire, spike;
  assign v_cur = v[idx];
  assign last = idx == AW'(N_NEURONS - 1);
  assign fire = v_cur >= THR;
  assign sum = {1'b0, v_cur >> LEAK_SHIFT} + {1'b0, cur[idx]};
  assign sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`ifdef LIF_SCHED_REFRACTORY_EN
  localparam int RW = $clog2(REFRACT_TICKS + 1);
  logic [RW-1:0] refr [N_NEURONS];
  logic refr_act;
  assign refr_act = refr[idx] != '0;
  assign spike = fire && !refr_act;
  assign v_nx = (spike || refr_act) ? '0 : sat;
`else
  assign spike = fire;
  assign v_nx = spike ? '0 : sat;
`endif
  assign rd_data = v[rd_addr];
  // busy covers the accepting tick cycle so a sweep occupies N_NEURONS+2 cycles
  assign busy = st != IDLE || tick;
  assign done = st == DONE;
  always_comb begin
    st_nx = st;
    st_nx = st == IDLE ? (tick ? UPDATE : IDLE) : st == UPDATE ? (last ? DONE : UPDATE) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      idx <= '0;
      shadow <= '0;
      spike_vec <= '0;
      spike_count <= '0;
      overrun <= 1'b0;
      for (int n = 0; n < N_NEURONS; n++) begin
        v[n] <= '0;
        cur[n] <= '0;
`ifdef LIF_SCHED_REFRACTORY_EN
        refr[n] <= '0;
`endif
      end
    end else begin
      st <= st_nx;
      if (cfg_we) cur[cfg_addr] <= cfg_data;
      if (tick && st != IDLE) overrun <= 1'b1;
      if (st == IDLE) begin
        idx <= '0;
        shadow <= '0;
      end
      if (st == UPDATE) begin
        v[idx] <= v_nx;
        shadow[idx] <= spike;
        idx <= idx + 1'b1;
        if (spike && spike_count != 8'hFF) spike_count <= spike_count + 8'd1;
        if (last) spike_vec <= shadow | (N_NEURONS'(spike) << idx);
`ifdef LIF_SCHED_REFRACTORY_EN
        refr[idx] <= refr_act ? refr[idx] - 1'b1 : spike ? RW'(REFRACT_TICKS) : refr[idx];
`endif
      end
    end
  end
endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// tb_lif_neuron_scheduler: directed scoreboard bench for lif_neuron_scheduler (default and THRESHOLD=255 instances).
module tb_lif_neuron_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, tick = 1'b0;
  logic [1:0] cfg_addr = '0, rd_addr = '0;
  logic [7:0] cfg_data = '0;
  logic [7:0] rd_data, rd_data_s, spike_count, spike_count_s;
  logic busy, busy_s, done, done_s, overrun, overrun_s;
  logic [3:0] spike_vec, spike_vec_s;
  int checks = 0, failures = 0;
  typedef struct {logic [7:0] rd; logic [3:0] sv;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  lif_neuron_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .tick(tick), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .spike_vec(spike_vec), .spike_count(spike_count), .overrun(overrun));
  lif_neuron_scheduler #(.THRESHOLD(255)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .tick(tick), .rd_addr(rd_addr), .rd_data(rd_data_s), .busy(busy_s), .done(done_s),
    .spike_vec(spike_vec_s), .spike_count(spike_count_s), .overrun(overrun_s));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask
  task automatic sweep(input string tag, input logic [7:0] rd, input logic [3:0] sv, input bit s,
                       input int wr_c = -1, input logic [1:0] wa = '0, input logic [7:0] wd = '0);
    exp_t e;
    bit seen = 1'b0;
    q.push_back('{rd: rd, sv: sv});
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      tick = c == 0;
      cfg_we = c == wr_c; cfg_addr = wa; cfg_data = wd;
      #1 seen = s ? done_s : done;
    end
    tick = 1'b0; cfg_we = 1'b0;
    e = q.pop_front();
    if (!seen) begin
      checks++; failures++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
    end else begin
      chk({tag, "_rd"}, s ? rd_data_s : rd_data, e.rd);
      chk({tag, "_sv"}, s ? spike_vec_s : spike_vec, e.sv);
    end
  endtask
  initial begin
    int busy_cnt, done_cnt, done_at;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_sv", spike_vec, 0);
    chk("rst_cnt", spike_count, 0); chk("rst_ovr", overrun, 0); chk("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    cfg(2'd0, 8'd120);
    rd_addr = 2'd0;
    sweep("if_t1", 8'd120, 4'b0000, 0);
    sweep("if_t2", 8'd180, 4'b0000, 0);
    sweep("if_t3", 8'd210, 4'b0000, 0);
    sweep("if_t4", 8'd0, 4'b0001, 0);
    chk("if_cnt", spike_count, 1);
    chk("if_ovr", overrun, 0);
`ifdef LIF_SCHED_REFRACTORY_EN
    sweep("ref_t5", 8'd0, 4'b0000, 0);
    sweep("ref_t6", 8'd0, 4'b0000, 0);
    sweep("ref_t7", 8'd120, 4'b0000, 0);
`else
    sweep("noref_t5", 8'd120, 4'b0000, 0);
`endif
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tick = c == 0 || c == 2;
      #1;
      busy_cnt += int'(busy);
      if (done) begin done_cnt++; done_at = c; end
    end
    tick = 1'b0;
    chk("hs_busy_cycles", busy_cnt, 6);
    chk("hs_done_cycles", done_cnt, 1);
    chk("hs_done_at", done_at, 5);
    chk("hs_ovr", overrun, 1);
    chk("hs_rd", rd_data, 8'd180);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0); chk("mid_done", done, 0); chk("mid_sv", spike_vec, 0);
    chk("mid_cnt", spike_count, 0); chk("mid_ovr", overrun, 0); chk("mid_rd", rd_data, 0);
    @(negedge clk); rst_n = 1'b1;
    busy_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      #1 busy_cnt += int'(busy) + int'(done);
    end
    chk("post_rst_idle", busy_cnt, 0);
    cfg(2'd2, 8'd10);
    rd_addr = 2'd2;
    sweep("wr_same", 8'd10, 4'b0000, 0, 3, 2'd2, 8'd50);
    sweep("wr_next", 8'd55, 4'b0000, 0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cfg(2'd1, 8'd250);
    rd_addr = 2'd1;
    sweep("sat_t1", 8'd250, 4'b0000, 1);
    sweep("sat_t2", 8'd255, 4'b0000, 1);
    sweep("sat_t3", 8'd0, 4'b0010, 1);
    chk("sat_cnt", spike_count_s, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lif_neuron_scheduler.md
# lif_neuron_scheduler

Time-multiplexed controller that shares one leaky-integrate-and-fire update datapath among `N_NEURONS` virtual neurons. Per neuron, it holds the membrane state and input current in registers. On each `tick` it sweeps every neuron through the shared update, one neuron per cycle, and publishes a spike vector at the end of the sweep. It sits between the top-level tile wrapper (switch inputs, bidirectional IOs) and the output pins, replacing one-instance-per-neuron replication.

## Interface
Parameters:
- `N_NEURONS`, 4: virtual neuron count. Power of two, 2..16.
- `WIDTH`, 8: membrane/current width.
- `THRESHOLD`, 200: spike when the pre-update state is ≥ THRESHOLD.
- `LEAK_SHIFT`, 1: leak is a right shift of the state.
- `REFRACT_TICKS`, 2: refractory length in ticks. Used only with the macro.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_we` in 1: write-enable for current registers.
- `cfg_addr` in log2(N_NEURONS): target neuron.
- `cfg_data` in WIDTH: current value.
- `tick` in 1: start one timestep sweep. Level-sampled.
- `rd_addr` in log2(N_NEURONS): membrane readout select.
- `rd_data` out WIDTH: combinational `state[rd_addr]`.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at sweep completion.
- `spike_vec` out N_NEURONS: spikes of the last completed sweep.
- `spike_count` out 8: saturating total spike count.
- `overrun` out 1: sticky; a tick arrived while busy.

## Operation
- Reset (asynchronous assert, synchronous release): all state, current and refractory registers are 0; FSM=IDLE; `busy`=0, `done`=0, `spike_vec`=0, `spike_count`=0, `overrun`=0.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE: `tick`=1 → UPDATE, idx=0.
  - UPDATE: update neuron idx; if idx=N_NEURONS-1 → DONE, else idx+1.
  - DONE → IDLE unconditionally.
- Per-neuron update (v = current state, I = current register):
  - spike = (v ≥ THRESHOLD).
  - sum = (v >> LEAK_SHIFT) + I, computed WIDTH+1 wide and saturated to 2^WIDTH-1.
  - v_next = spike ? 0 : sum.
  - The spike bit is accumulated into a shadow vector. Each spike increments `spike_count`, saturating at 255.
- The shadow vector is cleared on IDLE→UPDATE. It is copied to `spike_vec` on UPDATE→DONE.
- `cfg_we` is accepted in any state; the register updates at the edge.
  - A write to the neuron being updated in the same cycle: the update uses the old current, and the write lands.
  - Writes to not-yet-visited neurons affect the current sweep.
- `tick` in UPDATE or DONE is ignored and sets `overrun`. `overrun` clears only on reset.
- `rd_data` reflects committed state. Reading during a sweep returns a mix of new and old values by neuron.

## Timing
- `tick` high at edge k in IDLE:
  - `busy`=1 from k to k+N_NEURONS+1.
  - Neuron i is written at edge k+1+i.
  - `spike_vec` updates and `done`=1 from edge k+N_NEURONS.
  - FSM is back in IDLE after edge k+N_NEURONS+1; `busy`=0 and `done`=0.
- Sweep length is N_NEURONS+2 cycles per tick. Back-to-back ticks are accepted every N_NEURONS+2 cycles.
- `tick` held high in IDLE starts a new sweep each time IDLE is reached.
- Reset mid-sweep aborts immediately: all registers return to reset values and no `done` is produced.

## Configuration
- `LIF_SCHED_REFRACTORY_EN` defined:
  - Each neuron has a refractory counter, loaded with REFRACT_TICKS when it spikes.
  - While the counter is nonzero, the neuron's update forces v_next=0, ignores I, emits no spike, and decrements the counter.
- Undefined: no counters are present, and the neuron integrates on the tick immediately after the spike.

## Test plan
- Reset: assert `rst_n`=0 mid-sweep with states nonzero → all outputs 0, FSM IDLE. After release, `busy`=0 until the next `tick`.
- Integrate and fire (defaults): neuron 0 current 120, other neurons 0. Issue 4 ticks → `rd_data`(0) reads 120, 180, 210, then 0. `spike_vec`=4'b0001 only after the 4th tick. `spike_count`=1.
- Saturation (THRESHOLD=255): neuron 1 current 250 → states 250, 255 (saturated from 375), then the spike tick drives state to 0 with `spike_vec[1]`=1.
- Handshake latency: `tick` at edge k → `done` high exactly at edge k+4 (N=4) for one cycle, and `busy` high for 6 cycles. A `tick` during `busy` sets `overrun`=1 and does not extend the sweep.
- Same-cycle write: `cfg_we` to neuron 2 with value 50, in the cycle neuron 2 updates with old current 10 → state 10. The next tick uses 50: state 5+50=55.
- Refractory (macro on, REFRACT_TICKS=2, current 120): spike on tick 4; states 0, 0 on ticks 5–6; 120 on tick 7. With the macro off: state 120 on tick 5.
